spi_tx: RTL

Slave-side SPI transmitter that drives MISO back to the host controller, the return path for the existing mode-0 MOSI receiver. It shares `spi_clock`/`cs_n` with the receiver. It oversamples both in the FPGA `clock` domain and shifts out one 16-bit status/readback word per chip-select frame, MSB first. A one-entry holding register with a valid/ready handshake decouples producers (angle-done status, encoder readback) from frame timing.

---
 rtl/spi_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_tx.sv
// Slave-side SPI (mode 0) MISO transmitter: one 16-bit word per chip-select frame, MSB first,
// fed from a one-entry valid/ready holding register. Optional macro SPI_TX_CRC_EN replaces the low nibble with a CRC-4.
module spi_tx #(
  parameter logic [15:0] IDLE_WORD   = 16'h0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        spi_clock,
  input  logic        cs_n,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  output logic        abort
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic        frame_done_q, frame_done_d;
  logic        underrun_q, underrun_d;
  logic        abort_q, abort_d;

  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic        accept;
  logic [15:0] start_word, framed_word;

  assign sclk_rise =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
  assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_hist_q;
  assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1]   &  cs_hist_q;
  assign cs_rise   =  cs_sync_q[SYNC_STAGES-1]   & ~cs_hist_q;

  assign accept     = tx_valid & ~hold_full_q;
  assign start_word = hold_full_q ? hold_q : IDLE_WORD;

`ifdef SPI_TX_CRC_EN
  // CRC-4, polynomial x^4+x+1, init 0, fed MSB first over the upper 12 bits.
  function automatic logic [3:0] crc4(input logic [11:0] data);
    logic [3:0] crc;
    logic       fb;
    crc = 4'h0;
    for (int i = 11; i >= 0; i--) begin
      fb  = crc[3] ^ data[i];
      crc = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return crc;
  endfunction

  assign framed_word = {start_word[15:4], crc4(start_word[15:4])};
`else
  assign framed_word = start_word;
`endif

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_clock};
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sclk_hist_d  = sclk_sync_q[SYNC_STAGES-1];
    cs_hist_d    = cs_sync_q[SYNC_STAGES-1];
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    abort_d      = 1'b0;

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          // A word accepted this same cycle stays queued for the next frame.
          shift_d     = framed_word;
          underrun_d  = ~hold_full_q;
          hold_full_d = accept;
          bitcnt_d    = 5'd0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          abort_d = 1'b1;
          shift_d = 16'h0000;
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd15) begin
            frame_done_d = 1'b1;
            state_d      = ST_DONE;
          end
        end else if (sclk_fall && bitcnt_q >= 5'd1 && bitcnt_q <= 5'd15) begin
          shift_d = {shift_q[14:0], 1'b0};
        end
      end
      ST_DONE: begin
        if (cs_rise) begin
          shift_d = 16'h0000;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    miso_d = (state_q == ST_SHIFT) ? shift_q[15] : 1'b0;
    oe_d   = (state_d != ST_IDLE);
  end

  // The cs_n chain resets to "selected" so a chip select already low at reset release
  // is not mistaken for a new frame; the host must deselect first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sync_q  <= '0;
      cs_sync_q    <= '0;
      sclk_hist_q  <= 1'b0;
      cs_hist_q    <= 1'b0;
      state_q      <= ST_IDLE;
      hold_q       <= 16'h0000;
      hold_full_q  <= 1'b0;
      shift_q      <= 16'h0000;
      bitcnt_q     <= 5'd0;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      sclk_hist_q  <= sclk_hist_d;
      cs_hist_q    <= cs_hist_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      miso_q       <= miso_d;
      oe_q         <= oe_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      abort_q      <= abort_d;
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = oe_q;
  assign tx_ready   = ~hold_full_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign abort      = abort_q;

endmodule
